// File: rtl/clink_uart_tx.sv
// Camera Link SerTC transmitter: byte FIFO from the register block feeding an 8N1 UART.
// Frames are sent back-to-back while bytes remain queued; uart_tx is always registered.
module clink_uart_tx #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_aresetn,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx_busy,
    output logic                          overflow,
    input  logic                          clear_overflow,
    output logic                          uart_tx
);

    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam int          BIT_CYCLES = CLK_FREQ_HZ / BAUD_RATE;
    localparam logic [15:0] BAUD_LAST  = 16'(BIT_CYCLES - 1);
    localparam logic [AW:0] DEPTH_L    = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0] w_count;
    logic        w_full, w_empty, w_push, w_pop;
    logic [7:0]  w_head;

    state_t      r_state, w_state_nx;
    logic [15:0] r_baud, w_baud_nx;
    logic [2:0]  r_bit_idx, w_bit_nx;
    logic [7:0]  r_shift, w_shift_nx;
    logic        r_tx, w_tx_nx;
    logic        r_overflow;
    logic        w_bit_end;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == DEPTH_L);
    assign w_empty = (w_count == '0);
    assign w_push  = wr_en & ~w_full;
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge s_axi_aclk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // A write that finds the FIFO full is dropped even if a pop frees a slot this cycle.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn)        r_overflow <= 1'b0;
        else if (wr_en && w_full)  r_overflow <= 1'b1;
        else if (clear_overflow)   r_overflow <= 1'b0;
    end

    assign w_bit_end = (r_baud == BAUD_LAST);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nx;
            r_baud    <= w_baud_nx;
            r_bit_idx <= w_bit_nx;
            r_shift   <= w_shift_nx;
            r_tx      <= w_tx_nx;
        end
    end

    // Next-state logic also computes the next line level so uart_tx comes straight from a flop.
    always_comb begin
        w_state_nx = r_state;
        w_baud_nx  = r_baud + 16'd1;
        w_bit_nx   = r_bit_idx;
        w_shift_nx = r_shift;
        w_tx_nx    = r_tx;
        w_pop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_baud_nx = '0;
                w_tx_nx   = 1'b1;
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_shift_nx = w_head;
                    w_state_nx = S_START;
                    w_tx_nx    = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_baud_nx  = '0;
                    w_bit_nx   = '0;
                    w_state_nx = S_DATA;
                    w_tx_nx    = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_nx  = '0;
                    w_shift_nx = {1'b0, r_shift[7:1]};
                    w_bit_nx   = r_bit_idx + 3'd1;
                    w_tx_nx    = r_shift[1];
                    if (r_bit_idx == 3'd7) begin
                        w_state_nx = S_STOP;
                        w_tx_nx    = 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_baud_nx = '0;
                    if (!w_empty) begin
                        w_pop      = 1'b1;
                        w_shift_nx = w_head;
                        w_state_nx = S_START;
                        w_tx_nx    = 1'b0;
                    end else begin
                        w_state_nx = S_IDLE;
                        w_tx_nx    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_baud_nx  = '0;
                w_tx_nx    = 1'b1;
            end
        endcase
    end

    assign fifo_full  = w_full;
    assign fifo_count = w_count;
    assign tx_busy    = (r_state != S_IDLE);
    assign overflow   = r_overflow;
    assign uart_tx    = r_tx;

endmodule

// File: doc/clink_uart_tx.md
# clink_uart_tx

Camera Link serial-control transmitter (SerTC path). Accepts bytes from the AXI Camera Link interface register block (UART_WRITE register, offset 0x00) through a small FIFO. Serialises each byte as 8N1 UART at a fixed baud rate onto the FMC line driving the camera's SerTC input. It is the stage directly downstream of the AXI register write.

## Interface
Parameters:
- CLK_FREQ_HZ, 100_000_000: frequency of s_axi_aclk.
- BAUD_RATE, 9600: serial bit rate.
- FIFO_DEPTH, 16: byte FIFO depth; power of two, ≥2.

Ports:
- s_axi_aclk  in  1  sole clock; everything is synchronous to its rising edge.
- s_axi_aresetn  in  1  asynchronous, active-low reset.
- wr_en  in  1  one-cycle write strobe from the register block.
- wr_data  in  8  byte to transmit; sampled when wr_en=1.
- fifo_full  out  1  FIFO holds FIFO_DEPTH bytes.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the byte being shifted.
- tx_busy  out  1  high while a frame is on the line (START, DATA or STOP state).
- overflow  out  1  sticky flag: a write was dropped.
- clear_overflow  in  1  one-cycle pulse that clears overflow.
- uart_tx  out  1  serial line; idles high.

## Operation
- BIT_CYCLES = CLK_FREQ_HZ / BAUD_RATE, truncating integer division (10416 at the defaults). A 16-bit baud counter counts 0..BIT_CYCLES-1.
- FIFO: synchronous, registered write pointer and read pointer.
  - Write is accepted when wr_en=1 and the FIFO is not full.
  - When wr_en=1 and the FIFO is full, the byte is dropped and overflow is set. This holds even if a pop happens in the same cycle.
  - A push and a pop in the same cycle leave fifo_count unchanged.
- If clear_overflow and a dropping write occur in the same cycle, overflow ends that cycle set (set wins).
- FSM states:
  - IDLE: uart_tx=1. If fifo_count≠0, pop the head byte into the shift register, clear the baud counter, go to START.
  - START: uart_tx=0 for BIT_CYCLES cycles, then go to DATA with bit index 0.
  - DATA: uart_tx=shift[0] for BIT_CYCLES cycles per bit; shift right, LSB first. After bit index 7 completes, go to STOP.
  - STOP: uart_tx=1 for BIT_CYCLES cycles. At the end, if fifo_count≠0, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- uart_tx is driven from a register, so there is no combinational path to the pin.
- Reset values: uart_tx=1, tx_busy=0, fifo_full=0, fifo_count=0, overflow=0, FSM=IDLE, all pointers and counters 0.
- Reset mid-frame: the line returns high immediately (asynchronous) and the queued bytes are discarded. No partial frame resumes after reset release.

## Timing
- wr_en sampled at edge N with the FIFO empty and FSM in IDLE:
  - fifo_count=1 after edge N.
  - Pop at edge N+1: fifo_count=0, uart_tx=0, tx_busy=1 after edge N+1.
- Frame length is exactly 10×BIT_CYCLES cycles, measured from the uart_tx falling edge to the end of the stop bit.
- Back-to-back: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- tx_busy drops in the same cycle the FSM enters IDLE.
- fifo_full and fifo_count update on the edge after the push or pop.

## Test plan
- Defaults, write 0x48 once. Required line sequence: 0 (start), then 0,0,0,1,0,0,1,0, then 1 (stop). Each level lasts 10416 cycles, 104160 cycles total. Afterwards tx_busy=0 and uart_tx=1.
- Write 0x55 then 0xAA on consecutive cycles. Required: two frames with no idle cycle between them; fifo_count reads 1 after the first pop and 0 after the second pop.
- BAUD_RATE set so BIT_CYCLES=4. Write 18 bytes on consecutive cycles. Required:
  - Byte 1 popped; bytes 2–17 fill the FIFO (fifo_full=1, fifo_count=16).
  - Byte 18 is dropped and overflow=1.
  - Exactly 17 frames are sent, in order.
- With overflow=1, pulse clear_overflow alone → overflow=0. Then pulse clear_overflow in the same cycle as a write while full → overflow stays 1.
- Assert s_axi_aresetn low during DATA bit 3 with 5 bytes queued. Required:
  - uart_tx=1 and tx_busy=0 immediately; fifo_count=0.
  - After release, the line stays idle until a new write.
  - Then write 0x01: a clean frame 0, 1,0,0,0,0,0,0,0, 1.
- CLK_FREQ_HZ=100_000_000, BAUD_RATE=115200: BIT_CYCLES=868. Measure the frame at 8680 cycles ±0.
